// File: rtl/sha256_nonce_scanner.sv
// Nonce search engine around sha256_double: builds the padded second header block per nonce,
// issues one double hash at a time and compares each result against the target.
module sha256_nonce_scanner #(
  parameter bit SWAP_NONCE = 1'b1,
  parameter bit HASH_LE    = 1'b1,
  parameter int CNT_W      = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [255:0]     midstate_i,
  input  logic [95:0]      tail_words_i,
  input  logic [31:0]      nonce_start_i,
  input  logic [31:0]      nonce_end_i,
  input  logic [255:0]     target_i,
  output logic             dbl_start_o,
  output logic [511:0]     dbl_block_o,
  output logic             dbl_init_hash_o,
  output logic [255:0]     dbl_hash_in_o,
  input  logic             dbl_busy_i,
  input  logic             dbl_done_i,
  input  logic [255:0]     dbl_hash_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             found_o,
  output logic             exhausted_o,
  output logic             aborted_o,
  output logic [31:0]      found_nonce_o,
  output logic [255:0]     found_hash_o,
  output logic [CNT_W-1:0] tried_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_FIN} state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [255:0]       mid_q, mid_d, tgt_q, tgt_d, hash_q, hash_d, fhash_q, fhash_d;
  logic [95:0]        tail_q, tail_d;
  logic [31:0]        nonce_q, nonce_d, end_q, end_d, fnonce_q, fnonce_d;
  logic               abort_q, abort_d, busy_q, busy_d, done_q, done_d;
  logic               found_q, found_d, exh_q, exh_d, abt_q, abt_d, dstart_q, dstart_d;
  logic [CNT_W-1:0]   tried_q, tried_d;
  logic [511:0]       dblock_q, dblock_d;
  logic [255:0]       cmp_hash;
  logic [31:0]        nonce_field;
  logic               abort_seen;

  assign cmp_hash    = HASH_LE ? bswap256(hash_q) : hash_q;
  assign nonce_field = SWAP_NONCE ? bswap32(nonce_q) : nonce_q;
  assign abort_seen  = abort_q | abort_i;

  always_comb begin
    state_d  = state_q;
    mid_d    = mid_q;
    tail_d   = tail_q;
    nonce_d  = nonce_q;
    end_d    = end_q;
    tgt_d    = tgt_q;
    hash_d   = hash_q;
    abort_d  = abort_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    exh_d    = exh_q;
    abt_d    = abt_q;
    fnonce_d = fnonce_q;
    fhash_d  = fhash_q;
    tried_d  = tried_q;
    dstart_d = 1'b0;
    dblock_d = dblock_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mid_d    = midstate_i;
          tail_d   = tail_words_i;
          end_d    = nonce_end_i;
          tgt_d    = target_i;
          nonce_d  = nonce_start_i;
          abort_d  = 1'b0;
          busy_d   = 1'b1;
          found_d  = 1'b0;
          abt_d    = 1'b0;
          fnonce_d = '0;
          fhash_d  = '0;
          tried_d  = '0;
          if (nonce_start_i > nonce_end_i) begin
            exh_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            exh_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        abort_d = abort_seen;
        if (abort_seen) begin
          abt_d   = 1'b1;
          state_d = S_FIN;
        end else if (!dbl_busy_i) begin
          dblock_d = {tail_q, nonce_field, 8'h80, 312'h0, 64'h280};
          dstart_d = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        abort_d = abort_seen;
        if (dbl_done_i) begin
          hash_d  = dbl_hash_i;
          tried_d = tried_q + CNT_W'(1);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        abort_d = abort_seen;
        // A hit wins over abort and range end; the nonce never wraps past nonce_end.
        if (cmp_hash <= tgt_q) begin
          found_d  = 1'b1;
          fnonce_d = nonce_q;
          fhash_d  = hash_q;
          state_d  = S_FIN;
        end else if (abort_seen) begin
          abt_d   = 1'b1;
          state_d = S_FIN;
        end else if (nonce_q == end_q) begin
          exh_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          nonce_d = nonce_q + 32'd1;
          state_d = S_ISSUE;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mid_q    <= '0;
      tail_q   <= '0;
      nonce_q  <= '0;
      end_q    <= '0;
      tgt_q    <= '0;
      hash_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      exh_q    <= 1'b0;
      abt_q    <= 1'b0;
      fnonce_q <= '0;
      fhash_q  <= '0;
      tried_q  <= '0;
      dstart_q <= 1'b0;
      dblock_q <= '0;
    end else begin
      state_q  <= state_d;
      mid_q    <= mid_d;
      tail_q   <= tail_d;
      nonce_q  <= nonce_d;
      end_q    <= end_d;
      tgt_q    <= tgt_d;
      hash_q   <= hash_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      exh_q    <= exh_d;
      abt_q    <= abt_d;
      fnonce_q <= fnonce_d;
      fhash_q  <= fhash_d;
      tried_q  <= tried_d;
      dstart_q <= dstart_d;
      dblock_q <= dblock_d;
    end
  end

  assign dbl_start_o     = dstart_q;
  assign dbl_block_o     = dblock_q;
  assign dbl_init_hash_o = 1'b0;
  assign dbl_hash_in_o   = mid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign found_o         = found_q;
  assign exhausted_o     = exh_q;
  assign aborted_o       = abt_q;
  assign found_nonce_o   = fnonce_q;
  assign found_hash_o    = fhash_q;
  assign tried_o         = tried_q;

endmodule
